uart_tx_driver: RTL and testbench
=================================

// Module: uart_tx_driver
// PURPOSE
//  8N1 UART transmitter with a byte FIFO; the transmit-side counterpart of the UART
//  receive monitor. Runs on the same 16x-baud clock, so one bit = CLKS_PER_BIT txclk
//  cycles. Used in the xc7k325t sim bench to drive console input into the SoC UART RX
//  pin, e.g. scripted commands. Synthesizable; no file I/O.
// PARAMETERS
//  CLKS_PER_BIT  16  txclk cycles per serial bit; must be >= 2.
//  FIFO_AW       4   FIFO address width; depth = 2**FIFO_AW = 16 bytes.
//  STOP_BITS     1   number of stop bits; legal values are 1 or 2.
// PORTS
//  txclk       in   1          16x baud clock. This is the only clock.
//  reset_n     in   1          asynchronous, active-low reset.
//  tx_enable   in   1          1 = frames may start. 0 = the in-progress frame finishes, then the block holds idle.
//  tx_data     in   8          byte to enqueue.
//  tx_valid    in   1          enqueue request; a push occurs when tx_valid && tx_ready.
//  tx_ready    out  1          1 = FIFO not full.
//  tx_out      out  1          serial line; idles high; registered output.
//  tx_busy     out  1          1 = a frame (start..last stop) is on the line.
//  fifo_level  out  FIFO_AW+1  bytes currently queued (0..2**FIFO_AW).
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - tx_out=1, tx_busy=0, fifo_level=0, tx_ready=1; FIFO pointers=0; FSM=IDLE.
//   - Reset mid-frame aborts the frame; the line goes high immediately; queued bytes are discarded.
//  FIFO:
//   - Circular buffer; wr_ptr/rd_ptr each FIFO_AW+1 bits (wrap bit distinguishes full from empty).
//   - tx_ready = !full, computed from the registered level only. A pop in the same cycle
//     does not open a slot, so a push while full is ignored and the data is dropped.
//   - Push and pop in the same cycle: level is unchanged, and both take effect.
//  FSM states: IDLE -> START -> DATA -> STOP -> (START | IDLE).
//   - Counters: bit-timer cnt 0..CLKS_PER_BIT-1; bit index idx 0..7; shifter sh[7:0].
//   - IDLE: if tx_enable && !empty, pop into sh and go to START.
//       The next cycle is the first start-bit cycle: tx_out=0, tx_busy=1.
//       Latency from the push cycle into an empty FIFO to tx_out falling is 2 cycles.
//   - START: tx_out=0 for CLKS_PER_BIT cycles, then go to DATA with idx=0.
//   - DATA: tx_out=sh[0], LSB first. Each bit is held CLKS_PER_BIT cycles, then sh>>=1
//       and idx++. After idx==7 expires, go to STOP.
//   - STOP: tx_out=1 for STOP_BITS*CLKS_PER_BIT cycles. At the final cycle:
//       if tx_enable && !empty, pop and go directly to START, with no idle gap (back-to-back);
//       otherwise go to IDLE and tx_busy=0 the following cycle.
//   - Frame length = (10 + STOP_BITS - 1) * CLKS_PER_BIT cycles; 160 at the defaults.
//  tx_enable:
//   - Sampled only at IDLE and at the final STOP cycle.
//   - Deassertion mid-frame never truncates the frame.
//  tx_out and tx_busy are registered outputs; there is no combinational path from inputs to tx_out.
// TESTING
//  1. Reset, push 0x55 -> 2 cycles later tx_out low for 16 cycles, then 1,0,1,0,1,0,1,0
//     at 16 cycles each, then high; tx_busy is high for exactly 160 cycles.
//  2. Loop tx_out into the UART RX monitor and push "quit\r" -> the monitor log shows
//     the bytes 71 75 69 74 0d and the sim finishes.
//  3. Push 17 bytes back-to-back while tx_enable=0 -> first 16 accepted, fifo_level=16,
//     tx_ready=0, 17th dropped. Raise tx_enable -> 16 frames of 160 cycles with no gap
//     between them, then fifo_level=0.
//  4. Push 0xA5; drop tx_enable 40 cycles after tx_out falls -> the frame completes
//     intact; a second queued byte stays queued (fifo_level=1) until tx_enable returns.
//  5. Assert reset_n=0 during DATA bit 3 -> tx_out=1 and fifo_level=0 in the same cycle.
//     After release, the next push transmits correctly.
//  6. STOP_BITS=2, CLKS_PER_BIT=4: push 0x00, 0xFF -> each frame is 44 cycles, the stop
//     is high for 8 cycles, and there is no idle gap between the frames.

Source files
------------

// File: rtl/uart_tx_driver.sv
// uart_tx_driver: 8N1 UART transmitter with a circular byte FIFO.
// The bit timer runs on txclk, so one serial bit lasts CLKS_PER_BIT cycles.
// The FSM decides its next state combinationally. tx_out and tx_busy are then
// registered from that next state. As a result, the line changes on the same
// edge that the state changes, and no path runs from the inputs to tx_out.
module uart_tx_driver #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_AW      = 4,
    parameter int STOP_BITS    = 1
) (
    input  logic               txclk,
    input  logic               reset_n,
    input  logic               tx_enable,
    input  logic [7:0]         tx_data,
    input  logic               tx_valid,
    output logic               tx_ready,
    output logic               tx_out,
    output logic               tx_busy,
    output logic [FIFO_AW:0]   fifo_level
);

    localparam int STOP_LEN = STOP_BITS * CLKS_PER_BIT;
    localparam int CNT_MAX  = (STOP_LEN > CLKS_PER_BIT) ? STOP_LEN : CLKS_PER_BIT;
    localparam int CNT_W    = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
    localparam int DEPTH    = 2 ** FIFO_AW;

    localparam logic [CNT_W-1:0]   CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]   CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]   BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]   STOP_LAST = CNT_W'(STOP_LEN - 1);
    localparam logic [FIFO_AW:0]   PTR_ONE   = {{FIFO_AW{1'b0}}, 1'b1};

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    logic [1:0]         rst_sync_r;
    logic               rst_n_s;

    logic [7:0]         mem_r [DEPTH];
    logic [FIFO_AW:0]   wr_ptr_r;
    logic [FIFO_AW:0]   rd_ptr_r;
    logic [FIFO_AW:0]   level_r;
    logic               full_s;
    logic               empty_s;
    logic               push_s;
    logic               pop_s;
    logic [7:0]         rd_data_s;

    logic [1:0]         state_r;
    logic [1:0]         state_nx_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_nx_s;
    logic [2:0]         idx_r;
    logic [2:0]         idx_nx_s;
    logic [7:0]         sh_r;
    logic [7:0]         sh_nx_s;
    logic               tx_out_r;
    logic               tx_out_nx_s;
    logic               tx_busy_r;

    // Reset synchronizer: assertion is asynchronous and release is aligned to txclk
    always_ff @(posedge txclk or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync_r <= 2'b00;
        end else begin
            rst_sync_r <= {rst_sync_r[0], 1'b1};
        end
    end

    assign rst_n_s = rst_sync_r[1];

    // The full and empty flags come only from the registered level, so a pop does not open a slot in the same cycle
    assign full_s     = level_r[FIFO_AW];
    assign empty_s    = (level_r == {(FIFO_AW+1){1'b0}});
    assign push_s     = tx_valid & ~full_s;
    assign rd_data_s  = mem_r[rd_ptr_r[FIFO_AW-1:0]];
    assign tx_ready   = ~full_s;
    assign fifo_level = level_r;
    assign tx_out     = tx_out_r;
    assign tx_busy    = tx_busy_r;

    // FIFO storage: write the byte being accepted. The contents need no reset
    always_ff @(posedge txclk) begin
        if (push_s) begin
            mem_r[wr_ptr_r[FIFO_AW-1:0]] <= tx_data;
        end else begin
            mem_r[wr_ptr_r[FIFO_AW-1:0]] <= mem_r[wr_ptr_r[FIFO_AW-1:0]];
        end
    end

    // FIFO pointers and level. A push and a pop in the same cycle leave the level unchanged
    always_ff @(posedge txclk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            wr_ptr_r <= {(FIFO_AW+1){1'b0}};
            rd_ptr_r <= {(FIFO_AW+1){1'b0}};
            level_r  <= {(FIFO_AW+1){1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + PTR_ONE;
                2'b01:   level_r <= level_r - PTR_ONE;
                default: level_r <= level_r;
            endcase
        end
    end

    // Frame sequencer next-state: bit timing, bit index, shifter and FIFO pop
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        idx_nx_s   = idx_r;
        sh_nx_s    = sh_r;
        pop_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (tx_enable && !empty_s) begin
                    pop_s      = 1'b1;
                    sh_nx_s    = rd_data_s;
                    cnt_nx_s   = CNT_ZERO;
                    state_nx_s = ST_START;
                end else begin
                    cnt_nx_s   = CNT_ZERO;
                end
            end
            ST_START: begin
                if (cnt_r == BIT_LAST) begin
                    cnt_nx_s   = CNT_ZERO;
                    idx_nx_s   = 3'd0;
                    state_nx_s = ST_DATA;
                end else begin
                    cnt_nx_s   = cnt_r + CNT_ONE;
                end
            end
            ST_DATA: begin
                if (cnt_r == BIT_LAST) begin
                    cnt_nx_s = CNT_ZERO;
                    sh_nx_s  = {1'b0, sh_r[7:1]};
                    if (idx_r == 3'd7) begin
                        idx_nx_s   = 3'd0;
                        state_nx_s = ST_STOP;
                    end else begin
                        idx_nx_s   = idx_r + 3'd1;
                    end
                end else begin
                    cnt_nx_s = cnt_r + CNT_ONE;
                end
            end
            ST_STOP: begin
                if (cnt_r == STOP_LAST) begin
                    cnt_nx_s = CNT_ZERO;
                    if (tx_enable && !empty_s) begin
                        pop_s      = 1'b1;
                        sh_nx_s    = rd_data_s;
                        state_nx_s = ST_START;
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end else begin
                    cnt_nx_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                cnt_nx_s   = CNT_ZERO;
                idx_nx_s   = 3'd0;
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Line level for the state being entered: start bit low, data bit LSB first, idle and stop high
    always_comb begin
        tx_out_nx_s = 1'b1;
        case (state_nx_s)
            ST_START: tx_out_nx_s = 1'b0;
            ST_DATA:  tx_out_nx_s = sh_nx_s[0];
            default:  tx_out_nx_s = 1'b1;
        endcase
    end

    // Sequencer state and registered line outputs. Reset drives the line high at once
    always_ff @(posedge txclk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            state_r   <= ST_IDLE;
            cnt_r     <= CNT_ZERO;
            idx_r     <= 3'd0;
            sh_r      <= 8'h00;
            tx_out_r  <= 1'b1;
            tx_busy_r <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            cnt_r     <= cnt_nx_s;
            idx_r     <= idx_nx_s;
            sh_r      <= sh_nx_s;
            tx_out_r  <= tx_out_nx_s;
            tx_busy_r <= (state_nx_s != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_uart_tx_driver.sv
// tb_uart_tx_driver: directed bench for uart_tx_driver. One instance uses the
// default parameters. A second instance uses CLKS_PER_BIT=4 and STOP_BITS=2.
module tb_uart_tx_driver;

    logic       txclk;
    logic       reset_n;
    logic       tx_enable, tx_valid, tx_ready, tx_out, tx_busy;
    logic [7:0] tx_data;
    logic [4:0] fifo_level;
    logic       tx_enable2, tx_valid2, tx_ready2, tx_out2, tx_busy2;
    logic [7:0] tx_data2;
    logic [4:0] fifo_level2;

    int tests_run = 0;
    int tests_failed = 0;

    uart_tx_driver dut (
        .txclk(txclk), .reset_n(reset_n), .tx_enable(tx_enable),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_out(tx_out), .tx_busy(tx_busy), .fifo_level(fifo_level)
    );

    uart_tx_driver #(.CLKS_PER_BIT(4), .FIFO_AW(4), .STOP_BITS(2)) dut2 (
        .txclk(txclk), .reset_n(reset_n), .tx_enable(tx_enable2),
        .tx_data(tx_data2), .tx_valid(tx_valid2), .tx_ready(tx_ready2),
        .tx_out(tx_out2), .tx_busy(tx_busy2), .fifo_level(fifo_level2)
    );

    initial txclk = 1'b0;
    always #5 txclk = ~txclk;

    task automatic tick;
        @(posedge txclk);
        #1;
    endtask

    task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at the sample point of the first start-bit cycle. It walks the whole frame
    // and ends at the sample point of the first cycle after the frame.
    // sel=0 selects dut (16 clocks/bit, 1 stop). sel=1 selects dut2 (4 clocks/bit, 2 stops).
    task automatic frame_check(input int sel, input logic [7:0] b, input int drop_at, input string tag);
        int cpb   = (sel != 0) ? 4 : 16;
        int total = (sel != 0) ? 44 : 160;
        int errs  = 0;
        int bitn;
        logic exp_o, obs_o, obs_b;
        for (int c = 0; c < total; c++) begin
            bitn = c / cpb;
            if (bitn == 0) exp_o = 1'b0;
            else if (bitn <= 8) exp_o = b[bitn-1];
            else exp_o = 1'b1;
            obs_o = (sel != 0) ? tx_out2 : tx_out;
            obs_b = (sel != 0) ? tx_busy2 : tx_busy;
            if (obs_o !== exp_o) errs++;
            if (obs_b !== 1'b1) errs++;
            if (c == drop_at) tx_enable = 1'b0;
            tick();
        end
        check(errs, 0, tag);
    endtask

    logic [7:0] quit_s [5];

    initial begin
        quit_s[0] = 8'h71; quit_s[1] = 8'h75; quit_s[2] = 8'h69;
        quit_s[3] = 8'h74; quit_s[4] = 8'h0d;
        reset_n = 1'b0;
        tx_enable = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;
        tx_enable2 = 1'b1; tx_valid2 = 1'b0; tx_data2 = 8'h00;
        repeat (3) tick();
        reset_n = 1'b1;
        repeat (4) tick();

        // Reset state
        check(tx_out, 1, "rst_tx_out");
        check(tx_busy, 0, "rst_tx_busy");
        check(fifo_level, 0, "rst_level");
        check(tx_ready, 1, "rst_ready");
        check(tx_out2, 1, "rst_tx_out2");

        // Test 1: single 0x55 frame with a 2-cycle start latency
        tx_data = 8'h55; tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        check(fifo_level, 1, "t1_level_after_push");
        check(tx_out, 1, "t1_not_yet_low");
        tick();
        frame_check(0, 8'h55, -1, "t1_frame_55");
        check(tx_out, 1, "t1_idle_line");
        check(tx_busy, 0, "t1_busy_drop");
        check(fifo_level, 0, "t1_level_empty");

        // Test 2: "quit\r" queued, then sent back-to-back
        tx_enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tx_data = quit_s[i]; tx_valid = 1'b1;
            tick();
        end
        tx_valid = 1'b0;
        check(fifo_level, 5, "t2_level5");
        tx_enable = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) frame_check(0, quit_s[i], -1, "t2_quit_frame");
        check(tx_busy, 0, "t2_busy_drop");

        // Test 3: overfill while disabled, then 16 gapless frames
        tx_enable = 1'b0;
        for (int i = 0; i < 17; i++) begin
            tx_data = 8'h10 + 8'(i); tx_valid = 1'b1;
            tick();
        end
        tx_valid = 1'b0;
        check(fifo_level, 16, "t3_level_full");
        check(tx_ready, 0, "t3_ready_low");
        check(tx_busy, 0, "t3_held_idle");
        tx_enable = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) frame_check(0, 8'h10 + 8'(i), -1, "t3_b2b_frame");
        check(fifo_level, 0, "t3_level_drained");
        check(tx_out, 1, "t3_17th_dropped");
        check(tx_busy, 0, "t3_busy_drop");

        // Test 4: tx_enable drops mid-frame. The frame completes and the second byte stays queued
        tx_data = 8'hA5; tx_valid = 1'b1;
        tick();
        tx_data = 8'h3C;
        tick();
        tx_valid = 1'b0;
        check(fifo_level, 1, "t4_push_pop_level");
        frame_check(0, 8'hA5, 40, "t4_frame_a5");
        check(tx_busy, 0, "t4_held_idle");
        check(fifo_level, 1, "t4_still_queued");
        repeat (8) tick();
        check(fifo_level, 1, "t4_queued_later");
        check(tx_out, 1, "t4_line_idle");
        tx_enable = 1'b1;
        tick();
        frame_check(0, 8'h3C, -1, "t4_frame_3c");
        check(fifo_level, 0, "t4_level_empty");

        // Test 5: reset during DATA bit 3, then recovery
        tx_data = 8'hC3; tx_valid = 1'b1;
        tick();
        tx_data = 8'h81;
        tick();
        tx_valid = 1'b0;
        repeat (70) tick();
        check(tx_out, 0, "t5_bit3_low");
        reset_n = 1'b0;
        #1;
        check(tx_out, 1, "t5_rst_line_high");
        check(fifo_level, 0, "t5_rst_level");
        check(tx_busy, 0, "t5_rst_busy");
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (4) tick();
        tx_data = 8'h96; tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        tick();
        frame_check(0, 8'h96, -1, "t5_frame_96");
        check(fifo_level, 0, "t5_level_empty");

        // Test 6: 2 stop bits at 4 clocks/bit with back-to-back 0x00 and 0xFF
        tx_data2 = 8'h00; tx_valid2 = 1'b1;
        tick();
        tx_data2 = 8'hFF;
        tick();
        tx_valid2 = 1'b0;
        frame_check(1, 8'h00, -1, "t6_frame_00");
        frame_check(1, 8'hFF, -1, "t6_frame_ff");
        check(tx_out2, 1, "t6_idle_line");
        check(tx_busy2, 0, "t6_busy_drop");
        check(fifo_level2, 0, "t6_level_empty");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
